// File: rtl/hline_sampler.sv
// Horizontal-line bitstream sampler for the VGA scope: integrates a 1-bit stream per line
// window into a saturated 4-bit sample, and debounces four buttons into status flags.
module hline_sampler #(
  parameter int unsigned ACC_W     = 11,
  parameter int unsigned SHIFT     = 7,
  parameter int unsigned DEB_COUNT = 50000,
  parameter int unsigned DEB_W     = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ena,
  input  logic       hline,
  input  logic       din,
  input  logic [3:0] btn,
  output logic [3:0] sample,
  output logic       sample_valid,
  output logic [3:0] s
);

  localparam int unsigned NBTN = 4;
  localparam logic [ACC_W-1:0] ACC_MAX  = '1;
  localparam logic [ACC_W-1:0] SAMP_MAX = ACC_W'(15);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_COUNT - 1);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } deb_state_e;

  logic            din_meta_q, din_s_q;
  logic [NBTN-1:0] btn_meta_q, btn_s_q;

  logic [ACC_W-1:0] acc_q, acc_d, acc_shift;
  logic [3:0]       sample_q, sample_d;
  logic             sample_valid_q, sample_valid_d;

  deb_state_e       deb_state_q [NBTN];
  deb_state_e       deb_state_d [NBTN];
  logic [DEB_W-1:0] deb_cnt_q   [NBTN];
  logic [DEB_W-1:0] deb_cnt_d   [NBTN];
  logic [NBTN-1:0]  s_q, s_d;

  // Two-flop synchronisers run every cycle, independent of ena.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      din_meta_q <= 1'b0;
      din_s_q    <= 1'b0;
      btn_meta_q <= '0;
      btn_s_q    <= '0;
    end else begin
      din_meta_q <= din;
      din_s_q    <= din_meta_q;
      btn_meta_q <= btn;
      btn_s_q    <= btn_meta_q;
    end
  end

  // Window integration; the hline cycle's own bit opens the next window.
  always_comb begin
    acc_d          = acc_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    acc_shift      = acc_q >> SHIFT;
    if (ena) begin
      if (hline) begin
        sample_d       = (acc_shift > SAMP_MAX) ? 4'd15 : 4'(acc_shift);
        acc_d          = ACC_W'(din_s_q);
        sample_valid_d = 1'b1;
      end else if (din_s_q && (acc_q != ACC_MAX)) begin
        acc_d = acc_q + ACC_W'(1);
      end
    end
  end

  // Per-button debounce: a mismatch must persist DEB_COUNT enabled cycles to flip s.
  always_comb begin
    s_d = s_q;
    for (int i = 0; i < NBTN; i++) begin
      deb_state_d[i] = deb_state_q[i];
      deb_cnt_d[i]   = deb_cnt_q[i];
      if (ena) begin
        case (deb_state_q[i])
          ST_STABLE: begin
            if (btn_s_q[i] != s_q[i]) begin
              deb_state_d[i] = ST_COUNT;
              deb_cnt_d[i]   = DEB_W'(1);
            end else begin
              deb_cnt_d[i] = '0;
            end
          end
          ST_COUNT: begin
            if (btn_s_q[i] == s_q[i]) begin
              deb_state_d[i] = ST_STABLE;
              deb_cnt_d[i]   = '0;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
              s_d[i]         = btn_s_q[i];
              deb_state_d[i] = ST_STABLE;
              deb_cnt_d[i]   = '0;
            end else begin
              deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q          <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      s_q            <= '0;
      for (int i = 0; i < NBTN; i++) begin
        deb_state_q[i] <= ST_STABLE;
        deb_cnt_q[i]   <= '0;
      end
    end else begin
      acc_q          <= acc_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      s_q            <= s_d;
      for (int i = 0; i < NBTN; i++) begin
        deb_state_q[i] <= deb_state_d[i];
        deb_cnt_q[i]   <= deb_cnt_d[i];
      end
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign s            = s_q;

endmodule

// File: tb/tb_hline_sampler.sv
// Scoreboard bench for hline_sampler: a window-count / mismatch-run model predicts each
// sample pulse and each s change (value and cycle); a negedge monitor pops and compares.
module tb_hline_sampler;

  localparam int unsigned ACC_W     = 11;
  localparam int unsigned SHIFT     = 7;
  localparam int unsigned DEB_COUNT = 8;
  localparam int unsigned DEB_W     = 16;
  localparam int unsigned ACC_MAX   = (1 << ACC_W) - 1;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ena   = 1'b0;
  logic       hline = 1'b0;
  logic       din   = 1'b0;
  logic [3:0] btn   = 4'b0;
  logic [3:0] sample;
  logic       sample_valid;
  logic [3:0] s;

  hline_sampler #(
    .ACC_W    (ACC_W),
    .SHIFT    (SHIFT),
    .DEB_COUNT(DEB_COUNT),
    .DEB_W    (DEB_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .ena         (ena),
    .hline       (hline),
    .din         (din),
    .btn         (btn),
    .sample      (sample),
    .sample_valid(sample_valid),
    .s           (s)
  );

  initial forever #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]  val;
    int unsigned at;
  } exp_t;

  exp_t        exp_sample_q[$];
  exp_t        exp_s_q[$];
  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc   = 0;

  // Reference model state: raw input history, window bit count, debounce run lengths.
  int unsigned ones;
  logic        din_p1, din_p2;
  logic [3:0]  btn_p1, btn_p2;
  logic [3:0]  s_m;
  int unsigned run [4];
  logic [3:0]  btn_cur;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_clear();
    ones   = 0;
    din_p1 = 1'b0;
    din_p2 = 1'b0;
    btn_p1 = 4'b0;
    btn_p2 = 4'b0;
    s_m    = 4'b0;
    for (int i = 0; i < 4; i++) run[i] = 0;
    exp_sample_q.delete();
    exp_s_q.delete();
  endtask

  // Inputs reach the logic two edges after they are driven.
  task automatic model_edge(input logic d, input logic hl, input logic en, input logic [3:0] b);
    int unsigned v;
    logic        changed;
    if (en) begin
      if (hl) begin
        v = ((ones > ACC_MAX) ? ACC_MAX : ones) >> SHIFT;
        if (v > 15) v = 15;
        exp_sample_q.push_back('{val: 4'(v), at: cyc});
        ones = din_p2 ? 1 : 0;
      end else begin
        ones += din_p2 ? 1 : 0;
      end
      changed = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (btn_p2[i] != s_m[i]) begin
          run[i]++;
          if (run[i] == DEB_COUNT) begin
            s_m[i]  = btn_p2[i];
            run[i]  = 0;
            changed = 1'b1;
          end
        end else begin
          run[i] = 0;
        end
      end
      if (changed) exp_s_q.push_back('{val: s_m, at: cyc});
    end
    din_p2 = din_p1;
    din_p1 = d;
    btn_p2 = btn_p1;
    btn_p1 = b;
  endtask

  task automatic step(input logic d, input logic hl, input logic en, input logic [3:0] b);
    din   = d;
    hline = hl;
    ena   = en;
    btn   = b;
    @(posedge clock);
    #1;
    cyc++;
    model_edge(d, hl, en, b);
  endtask

  // mode: 0 = din low, 1 = din high, 2 = alternating 1,0
  task automatic run_window(input int unsigned len, input int unsigned mode);
    logic d;
    for (int k = 0; k < int'(len); k++) begin
      d = (mode == 1) ? 1'b1 : (mode == 2) ? ((k % 2) == 0) : 1'b0;
      step(d, k == int'(len) - 1, 1'b1, btn_cur);
    end
  endtask

  task automatic drain_check();
    check("sample_queue_drained", exp_sample_q.size(), 0);
    check("s_queue_drained", exp_s_q.size(), 0);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("reset_sample", 32'(sample), 0);
    check("reset_valid", 32'(sample_valid), 0);
    check("reset_s", 32'(s), 0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    model_clear();
    reset = 1'b0;
  endtask

  // Monitor: every sample pulse and every s change must match the next expectation.
  logic [3:0] prev_s = 4'b0;
  exp_t       e;
  always @(negedge clock) begin
    if (reset) begin
      prev_s = s;
    end else begin
      if (sample_valid) begin
        if (exp_sample_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sample_unexpected: got sample %0d with no window closed (cycle %0d)", sample, cyc);
        end else begin
          e = exp_sample_q.pop_front();
          check("sample_value", 32'(sample), 32'(e.val));
          check("sample_cycle", cyc, e.at);
        end
      end
      if (s != prev_s) begin
        if (exp_s_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL s_unexpected: got s %b, was %b (cycle %0d)", s, prev_s, cyc);
        end else begin
          e = exp_s_q.pop_front();
          check("s_value", 32'(s), 32'(e.val));
          check("s_cycle", cyc, e.at);
        end
        prev_s = s;
      end
    end
  end

  int unsigned per, wcnt, dens;
  logic        en_r, hl_r, d_r;

  initial begin
    btn_cur = 4'b0;
    model_clear();
    #1;
    apply_reset();

    // Full-density windows of 1600 cycles.
    for (int w = 0; w < 3; w++) run_window(1600, 1);
    // Half density, then empty windows.
    for (int w = 0; w < 2; w++) run_window(1600, 2);
    for (int w = 0; w < 2; w++) run_window(1600, 0);
    // Long windows saturate the accumulator.
    for (int w = 0; w < 2; w++) run_window(4000, 1);
    // Back-to-back hline gives a one-cycle window.
    step(1'b1, 1'b1, 1'b1, btn_cur);
    step(1'b1, 1'b1, 1'b1, btn_cur);

    // Debounce: held press on btn[2], short glitch on btn[0].
    btn_cur = 4'b0100;
    repeat (20) step(1'b0, 1'b0, 1'b1, btn_cur);
    btn_cur = 4'b0101;
    repeat (5) step(1'b0, 1'b0, 1'b1, btn_cur);
    btn_cur = 4'b0100;
    repeat (20) step(1'b0, 1'b0, 1'b1, btn_cur);

    // ena pause mid-window, with a btn[1] debounce straddling the pause.
    for (int k = 0; k < 1700; k++) begin
      if (k == 695) btn_cur = 4'b0110;
      en_r = !(k >= 700 && k < 800);
      step(1'b1, k == 1699, en_r, btn_cur);
    end
    run_window(1600, 1);

    // Build up s=1010 and a partial window, then reset mid-window.
    btn_cur = 4'b1010;
    repeat (20) step(1'b0, 1'b0, 1'b1, btn_cur);
    repeat (900) step(1'b1, 1'b0, 1'b1, btn_cur);
    @(negedge clock);
    #1;
    drain_check();
    apply_reset();
    btn_cur = 4'b0;
    run_window(300, 1);
    run_window(300, 1);

    // Randomised windows, densities, enables and button activity.
    per  = 100;
    wcnt = 0;
    dens = 50;
    for (int it = 0; it < 8000; it++) begin
      en_r = ($urandom_range(0, 15) != 0);
      hl_r = en_r && (wcnt >= per);
      d_r  = ($urandom_range(0, 99) < dens);
      if ($urandom_range(0, 29) == 0) btn_cur[$urandom_range(0, 3)] ^= 1'b1;
      step(d_r, hl_r, en_r, btn_cur);
      if (en_r) wcnt++;
      if (hl_r) begin
        wcnt = 0;
        per  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(50, 2200);
        dens = $urandom_range(0, 100);
      end
    end

    repeat (5) step(1'b0, 1'b0, 1'b1, btn_cur);
    @(negedge clock);
    #1;
    drain_check();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
